// File: rtl/cic_integrator_decim.sv
// cic_integrator_decim
//   Integrator-and-decimate front half of a CIC decimation filter. N cascaded
//   two's-complement integrators run at the input sample rate, and one of
//   every R integrated samples is kept. Each kept sample is presented on
//   o_data together with a one-cycle o_ready strobe. o_data/o_ready are meant
//   to drive the i_data/i_ce inputs of the downstream comb stage.
//
// Parameters
//   IW : input sample width (signed)
//   OW : accumulator/output width (signed); OW >= IW + N*ceil(log2(R)), OW > IW
//   N  : number of integrator stages (>= 1)
//   R  : decimation ratio (>= 2)
//
// Ports
//   i_clk   : single clock, rising edge
//   i_reset : synchronous active-high reset
//   i_ce    : input-sample strobe; i_data is consumed on every cycle it is high
//   i_data  : signed input sample
//   o_data  : signed decimated integrator output, held between strobes
//   o_ready : one-cycle strobe marking a new o_data
module cic_integrator_decim #(
  parameter int IW = 4,
  parameter int OW = 25,
  parameter int N  = 7,
  parameter int R  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_data,
  output logic signed [OW-1:0] o_data,
  output logic                 o_ready
);

  localparam int CW = $clog2(R);
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  logic signed [OW-1:0] acc_q [N];
  logic signed [OW-1:0] acc_d [N];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [OW-1:0] o_data_q, o_data_d;
  logic                 o_ready_q, o_ready_d;
  logic signed [OW-1:0] sample_ext;

  assign sample_ext = {{(OW - IW){i_data[IW-1]}}, i_data};

  // Integrator cascade and decimation counter. Every stage reads the
  // pre-edge value of its predecessor, so the cascade is registered: a
  // sample reaches the last stage N-1 accepted samples after it entered.
  // Additions wrap modulo 2^OW on purpose; the comb stage undoes the wrap.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      acc_d[k] = acc_q[k];
    end
    cnt_d     = cnt_q;
    o_data_d  = o_data_q;
    o_ready_d = 1'b0;

    if (i_ce) begin
      acc_d[0] = acc_q[0] + sample_ext;
      for (int k = 1; k < N; k++) begin
        acc_d[k] = acc_q[k] + acc_q[k-1];
      end

      // The kept sample is the post-edge value of the last stage, so the
      // strobe coincides with the edge consuming the R-th sample.
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        o_data_d  = acc_d[N-1];
        o_ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register; reset clears partial sums and re-establishes the
  // decimation phase, taking priority over i_ce.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q     <= '0;
      o_data_q  <= '0;
      o_ready_q <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= acc_d[k];
      end
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
      o_ready_q <= o_ready_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_ready = o_ready_q;

endmodule

// File: tb/tb_cic_integrator_decim.sv
// Testbench for cic_integrator_decim. Four instances with different
// (N, R, OW) share one clock, reset, strobe and input stream. Expected
// outputs come from a closed-form model: after m accepted samples x[0..m-1],
// the last integrator of an N-stage registered cascade holds
//   sum_j x[j] * C(m-1-j, N-1)   (mod 2^OW).
module tb_cic_integrator_decim;

  localparam int NUM_DUT = 4;
  localparam int CFG_N  [NUM_DUT] = '{7, 1, 2, 1};
  localparam int CFG_R  [NUM_DUT] = '{8, 4, 4, 10};
  localparam int CFG_OW [NUM_DUT] = '{25, 8, 8, 6};

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [3:0] dIn;

  logic [24:0] dataU0;
  logic [7:0]  dataU1;
  logic [7:0]  dataU2;
  logic [5:0]  dataU3;
  logic        readyU0, readyU1, readyU2, readyU3;

  longint unsigned obsData  [NUM_DUT];
  longint unsigned obsReady [NUM_DUT];
  longint unsigned expData  [NUM_DUT];
  longint unsigned expReady [NUM_DUT];
  longint          samples  [$];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  cic_integrator_decim #(.IW(4), .OW(25), .N(7), .R(8)) u0 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(dIn),
    .o_data(dataU0), .o_ready(readyU0));
  cic_integrator_decim #(.IW(4), .OW(8), .N(1), .R(4)) u1 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(dIn),
    .o_data(dataU1), .o_ready(readyU1));
  cic_integrator_decim #(.IW(4), .OW(8), .N(2), .R(4)) u2 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(dIn),
    .o_data(dataU2), .o_ready(readyU2));
  cic_integrator_decim #(.IW(4), .OW(6), .N(1), .R(10)) u3 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(dIn),
    .o_data(dataU3), .o_ready(readyU3));

  always_comb begin
    obsData[0]  = 64'(dataU0);
    obsData[1]  = 64'(dataU1);
    obsData[2]  = 64'(dataU2);
    obsData[3]  = 64'(dataU3);
    obsReady[0] = 64'(readyU0);
    obsReady[1] = 64'(readyU1);
    obsReady[2] = 64'(readyU2);
    obsReady[3] = 64'(readyU3);
  end

  function automatic longint binom(input longint a, input int b);
    longint c;
    if (a < 0 || a < longint'(b)) return 0;
    c = 1;
    for (int i = 0; i < b; i++) begin
      c = c * (a - i) / (i + 1);
    end
    return c;
  endfunction

  function automatic longint unsigned modelValue(input int n, input int ow);
    longint acc;
    longint unsigned mask;
    int m;
    m   = samples.size();
    acc = 0;
    for (int j = 0; j < m; j++) begin
      acc += samples[j] * binom(longint'(m - 1 - j), n - 1);
    end
    mask = (64'd1 << ow) - 64'd1;
    return longint'(acc) & mask;
  endfunction

  task automatic updateModel();
    if (rst) begin
      samples.delete();
      for (int i = 0; i < NUM_DUT; i++) begin
        expData[i]  = 0;
        expReady[i] = 0;
      end
    end else if (ce) begin
      samples.push_back(longint'($signed(dIn)));
      for (int i = 0; i < NUM_DUT; i++) begin
        if (samples.size() % CFG_R[i] == 0) begin
          expReady[i] = 1;
          expData[i]  = modelValue(CFG_N[i], CFG_OW[i]);
        end else begin
          expReady[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_DUT; i++) expReady[i] = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input longint unsigned observed,
                             input longint unsigned expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic checkAll();
    for (int i = 0; i < NUM_DUT; i++) begin
      checkOutput($sformatf("u%0d_ready", i), obsReady[i], expReady[i]);
      checkOutput($sformatf("u%0d_data", i), obsData[i], expData[i]);
    end
  endtask

  // Drive one cycle: inputs change just after an edge, the model follows the
  // next edge and outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic r, input logic c, input logic [3:0] d);
    rst = r;
    ce  = c;
    dIn = d;
    @(posedge clk);
    updateModel();
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b0;
    dIn = '0;

    $display("[TB] reset with ce high and data 5");
    applyStimulus(1'b1, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b1, 4'd5);
    checkOutput("reset_u0_data", obsData[0], 0);
    checkOutput("reset_u1_ready", obsReady[1], 0);

    $display("[TB] step input of 1");
    for (int s = 1; s <= 12; s++) begin
      applyStimulus(1'b0, 1'b1, 4'd1);
      if (s == 4) begin
        checkOutput("plan_u1_s4", obsData[1], 4);
        checkOutput("plan_u2_s4", obsData[2], 6);
      end
      if (s == 8) begin
        checkOutput("plan_u1_s8", obsData[1], 8);
        checkOutput("plan_u2_s8", obsData[2], 28);
      end
      if (s == 12) checkOutput("plan_u1_s12", obsData[1], 12);
    end

    $display("[TB] wrap-around with data 7");
    applyStimulus(1'b1, 1'b0, 4'd0);
    for (int s = 1; s <= 20; s++) begin
      applyStimulus(1'b0, 1'b1, 4'd7);
      if (s == 10) checkOutput("plan_u3_s10", obsData[3], 6);
      if (s == 20) checkOutput("plan_u3_s20", obsData[3], 12);
    end

    $display("[TB] ce every third cycle with data 2");
    applyStimulus(1'b1, 1'b0, 4'd0);
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b0, (c % 3) == 0, 4'd2);
      if (c == 9)  checkOutput("plan_gap_s4", obsData[1], 8);
      if (c == 21) checkOutput("plan_gap_s8", obsData[1], 16);
    end

    $display("[TB] reset mid-frame with data 3");
    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd3);
    applyStimulus(1'b0, 1'b1, 4'd3);
    applyStimulus(1'b1, 1'b1, 4'd3);
    for (int s = 1; s <= 4; s++) begin
      applyStimulus(1'b0, 1'b1, 4'd3);
      if (s == 2) checkOutput("plan_midrst_oldphase", obsReady[1], 0);
    end
    checkOutput("plan_midrst_ready", obsReady[1], 1);
    checkOutput("plan_midrst_data", obsData[1], 12);

    $display("[TB] randomized stream");
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(63) == 0, $urandom_range(9) < 7,
                    4'($urandom_range(15)));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
